// File: rtl/axis_fifo_pkg.sv
// Shared constants, data type and width helper for the axis_fifo slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 8;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  // Ceiling log2 for sizing address fields from an entry count.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_if.sv
// Producer/consumer bundle for axis_fifo; error flags exist only with AXIS_FIFO_ERR_FLAGS_EN.
// Latency: n/a (wires only).
// Backpressure: signalled to the producer through fifo_afull; consumer watches fifo_empty.
interface axis_fifo_if import axis_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  fifo_empty;
  logic                  fifo_afull;
`ifdef AXIS_FIFO_ERR_FLAGS_EN
  logic                  ovf_err;
  logic                  udf_err;

  modport master (output wr_en, wr_data, rd_en,
                  input  rd_data, fifo_empty, fifo_afull, ovf_err, udf_err);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output rd_data, fifo_empty, fifo_afull, ovf_err, udf_err);
`else
  modport master (output wr_en, wr_data, rd_en,
                  input  rd_data, fifo_empty, fifo_afull);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output rd_data, fifo_empty, fifo_afull);
`endif

endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one registered read port.
// Latency: read data appears one cycle after the edge that samples rd_en.
// Backpressure: none; callers only issue accepted reads/writes.
module axis_fifo_mem import axis_fifo_pkg::*; #(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Output word only moves on a read; otherwise it holds the last value.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Storage is deliberately not reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!resetn) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_fifo.sv
// Single-clock FIFO: wrap-bit pointers, accept logic, empty/almost-full flags; AXIS_FIFO_ERR_FLAGS_EN adds sticky ovf/udf.
// Latency: rd_data valid the cycle after the accepting edge; flags follow pointers with no extra lag.
// Backpressure: writes dropped when full (unless a read frees a slot that edge); reads ignored when empty.
module axis_fifo import axis_fifo_pkg::*; #(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int AFULL_MARGIN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  axis_fifo_if.slave  bus
);

  localparam int              ADDR_W   = clog2(DEPTH);
  localparam logic [ADDR_W:0] AFULL_TH = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count;
  logic            full, empty;
  logic            rd_acc, wr_acc;

  // Full when the addresses coincide but one pointer has lapped the other.
  always_comb begin
    full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
             (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    empty  = (wr_ptr_q == rd_ptr_q);
    count  = wr_ptr_q - rd_ptr_q;
    rd_acc = bus.rd_en && !empty;
    // A read on the same edge frees the slot, so a full FIFO can still take a write.
    wr_acc = bus.wr_en && (!full || rd_acc);
  end

  // Pointers advance on acceptance and wrap naturally modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset discards everything stored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign bus.fifo_empty = empty;
  assign bus.fifo_afull = (count >= AFULL_TH);

  axis_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (bus.rd_data)
  );

`ifdef AXIS_FIFO_ERR_FLAGS_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  // Sticky: a dropped write or a read against an empty FIFO latches until reset.
  always_comb begin
    ovf_err_d = ovf_err_q || (bus.wr_en && !wr_acc);
    udf_err_d = udf_err_q || (bus.rd_en && empty);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign bus.ovf_err = ovf_err_q;
  assign bus.udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo against a queue-based reference model.
// Latency: model expects rd_data one cycle after the accepting edge.
// Backpressure: model drops writes at 8 entries unless a read is accepted the same edge.
module tb_axis_fifo;

  localparam int DEPTH        = 8;
  localparam int AFULL_MARGIN = 1;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  axis_fifo_if #(.DATA_WIDTH(16)) bus ();

  axis_fifo #(
    .DEPTH        (DEPTH),
    .DATA_WIDTH   (16),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents in arrival order, last read word, sticky flags.
  logic [15:0] q [$];
  logic [15:0] m_rd  = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  function automatic logic m_afull();
    return (q.size() >= DEPTH - AFULL_MARGIN);
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, return 1 time unit after it.
  task automatic drive(input logic rst_n, input logic we, input logic [15:0] wd, input logic re);
    bit racc, wacc;
    @(negedge clk);
    resetn      = rst_n;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_rd  = 16'h0000;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      racc = re && (q.size() != 0);
      wacc = we && ((q.size() < DEPTH) || racc);
      if (re && q.size() == 0) m_udf = 1'b1;
      if (we && !wacc)         m_ovf = 1'b1;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(wd);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", bus.rd_data); end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.fifo_empty); end
    checks++; if (bus.fifo_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", bus.fifo_afull); end
`ifdef AXIS_FIFO_ERR_FLAGS_EN
    checks++; if ({bus.ovf_err, bus.udf_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b%b exp 00", bus.ovf_err, bus.udf_err); end
`endif
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got %b exp 1", bus.fifo_empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 16'(i), 1'b0);
      checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL fill_empty w%0d got %b exp 0", i, bus.fifo_empty); end
      checks++; if (bus.fifo_afull !== 1'(i >= 7)) begin errors++; $display("FAIL fill_afull w%0d got %b exp %b", i, bus.fifo_afull, i >= 7); end
    end
    drive(1'b1, 1'b1, 16'hDEAD, 1'b0);
    checks++; if (bus.fifo_afull !== 1'b1) begin errors++; $display("FAIL overflow_afull got %b exp 1", bus.fifo_afull); end
`ifdef AXIS_FIFO_ERR_FLAGS_EN
    checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL overflow_ovf_err got %b exp 1", bus.ovf_err); end
    checks++; if (bus.udf_err !== 1'b0) begin errors++; $display("FAIL overflow_udf_err got %b exp 0", bus.udf_err); end
`endif
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++; if (bus.rd_data !== 16'((k <= 8) ? k : 8)) begin errors++; $display("FAIL drain_data r%0d got %h exp %h", k, bus.rd_data, 16'((k <= 8) ? k : 8)); end
      checks++; if (bus.fifo_empty !== 1'(k >= 8)) begin errors++; $display("FAIL drain_empty r%0d got %b exp %b", k, bus.fifo_empty, k >= 8); end
      checks++; if (bus.fifo_afull !== 1'(k < 2)) begin errors++; $display("FAIL drain_afull r%0d got %b exp %b", k, bus.fifo_afull, k < 2); end
    end
`ifdef AXIS_FIFO_ERR_FLAGS_EN
    checks++; if (bus.udf_err !== 1'b1) begin errors++; $display("FAIL drain_udf_err got %b exp 1", bus.udf_err); end
    checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky got %b exp 1", bus.ovf_err); end
`endif
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 16'($urandom), 1'b0);
      for (int i = 0; i < 6; i++) begin
        exp = q[0];
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL wrap_data p%0d r%0d got %h exp %h", r, i, bus.rd_data, exp); end
      end
      checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty p%0d got %b exp 1", r, bus.fifo_empty); end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp;
    logic [15:0] w;
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp = q[0];
      drive(1'b1, 1'b1, 16'($urandom), 1'b1);
      checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL simul4_data c%0d got %h exp %h", i, bus.rd_data, exp); end
      checks++; if ({bus.fifo_empty, bus.fifo_afull} !== 2'b00) begin errors++; $display("FAIL simul4_flags c%0d got %b%b exp 00", i, bus.fifo_empty, bus.fifo_afull); end
    end
    for (int i = 0; i < 4; i++) begin
      exp = q[0];
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL simul4_drain r%0d got %h exp %h", i, bus.rd_data, exp); end
      checks++; if (bus.fifo_empty !== 1'(i == 3)) begin errors++; $display("FAIL simul4_empty r%0d got %b exp %b", i, bus.fifo_empty, i == 3); end
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'($urandom), 1'b0);
    exp = q[0];
    drive(1'b1, 1'b1, 16'($urandom), 1'b1);
    checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL simulfull_data got %h exp %h", bus.rd_data, exp); end
    checks++; if (bus.fifo_afull !== 1'b1) begin errors++; $display("FAIL simulfull_afull got %b exp 1", bus.fifo_afull); end
    for (int i = 0; i < 8; i++) begin
      exp = q[0];
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL simulfull_drain r%0d got %h exp %h", i, bus.rd_data, exp); end
      checks++; if (bus.fifo_empty !== 1'(i == 7)) begin errors++; $display("FAIL simulfull_empty r%0d got %b exp %b", i, bus.fifo_empty, i == 7); end
    end
    exp = m_rd;
    w   = 16'($urandom);
    drive(1'b1, 1'b1, w, 1'b1);
    checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL simulempty_empty got %b exp 0", bus.fifo_empty); end
    checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL simulempty_hold got %h exp %h", bus.rd_data, exp); end
`ifdef AXIS_FIFO_ERR_FLAGS_EN
    checks++; if (bus.udf_err !== 1'b1) begin errors++; $display("FAIL simulempty_udf got %b exp 1", bus.udf_err); end
`endif
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    checks++; if (bus.rd_data !== w) begin errors++; $display("FAIL simulempty_data got %h exp %h", bus.rd_data, w); end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL simulempty_after got %b exp 1", bus.fifo_empty); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] exp;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16'($urandom), 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got %b exp 1", bus.fifo_empty); end
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL midreset_rd_data got %h exp 0000", bus.rd_data); end
    drive(1'b1, 1'b1, 16'hA5A1, 1'b0);
    drive(1'b1, 1'b1, 16'h5A52, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp = (i == 0) ? 16'hA5A1 : 16'h5A52;
      drive(1'b1, 1'b0, 16'h0000, 1'b1);
      checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL midreset_data r%0d got %h exp %h", i, bus.rd_data, exp); end
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    checks++; if (bus.rd_data !== 16'h5A52) begin errors++; $display("FAIL midreset_hold got %h exp 5a52", bus.rd_data); end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL midreset_final_empty got %b exp 1", bus.fifo_empty); end
  endtask

  task automatic test_random();
    logic rst_n, we, re;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      we    = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re    = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(rst_n, we, 16'($urandom), re);
      checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL rand_data c%0d got %h exp %h", i, bus.rd_data, m_rd); end
      checks++; if (bus.fifo_empty !== 1'(q.size() == 0)) begin errors++; $display("FAIL rand_empty c%0d got %b exp %b", i, bus.fifo_empty, q.size() == 0); end
      checks++; if (bus.fifo_afull !== m_afull()) begin errors++; $display("FAIL rand_afull c%0d got %b exp %b", i, bus.fifo_afull, m_afull()); end
`ifdef AXIS_FIFO_ERR_FLAGS_EN
      checks++; if ({bus.ovf_err, bus.udf_err} !== {m_ovf, m_udf}) begin errors++; $display("FAIL rand_errs c%0d got %b%b exp %b%b", i, bus.ovf_err, bus.udf_err, m_ovf, m_udf); end
`endif
    end
  endtask

  initial begin
    resetn      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 16'h0000;
    bus.rd_en   = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
